// File: rtl/pll_recfg_pkg.sv
// Shared types and PLL management-port constants for the PLL reconfiguration sequencer.
package pll_recfg_pkg;

   typedef enum logic [2:0] {
      OP_UP         = 3'd0,
      OP_DOWN       = 3'd1,
      OP_REAPPLY    = 3'd2,
      OP_AUTO_START = 3'd3,
      OP_SET        = 3'd4
   } op_e;

   typedef enum logic [2:0] {
      S_IDLE,
      S_WRITE,
      S_PRST,
      S_SETTLE,
      S_LOCKWAIT
   } state_e;

   localparam logic [5:0] ADDR_START = 6'd0;
   localparam logic [5:0] ADDR_APPLY = 6'd2;
   localparam logic [5:0] ADDR_N     = 6'd3;
   localparam logic [5:0] ADDR_M     = 6'd4;
   localparam logic [5:0] ADDR_C     = 6'd5;
   localparam logic [5:0] ADDR_K     = 6'd7;
   localparam logic [5:0] ADDR_BW    = 6'd8;
   localparam logic [5:0] ADDR_CP    = 6'd9;

   localparam logic [31:0] N_BYPASS = 32'h0001_0000;
   localparam logic [31:0] CP_VAL   = 32'd1;
   localparam logic [31:0] BW_VAL   = 32'd7;

endpackage

// File: rtl/pll_sync2.sv
// Two-flop synchroniser for the asynchronous PLL lock indication; 2-cycle latency, no backpressure.
module pll_sync2 (
   input  logic CLK_50M,
   input  logic RESET,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge CLK_50M) begin
      if (RESET) begin
         meta <= 1'b0;
         q    <= 1'b0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/pll_recfg_seq.sv
// Programs one frequency-table row into the PLL, pulses PLL reset and waits for lock (first write 1 cycle after accept).
// Commands are only accepted while idle (cmd_ready = ~busy); mgmt_waitrequest stalls the current write slot.
module pll_recfg_seq
   import pll_recfg_pkg::*;
#(
   parameter int ENTRIES      = 38,
   parameter int NUM_C        = 1,
   parameter int GAP          = 8,
   parameter int LOCK_TIMEOUT = 5000000,
   localparam int PW          = $clog2(ENTRIES)
) (
   input  logic                  CLK_50M,
   input  logic                  RESET,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic [2:0]            cmd_op,
   input  logic [PW-1:0]         cmd_idx,
   input  logic                  auto_pass,
   output logic [PW-1:0]         tbl_idx,
   input  logic [31:0]           tbl_m,
   input  logic [31:0]           tbl_k,
   input  logic [32*NUM_C-1:0]   tbl_c,
   output logic [5:0]            mgmt_address,
   output logic [31:0]           mgmt_writedata,
   output logic                  mgmt_write,
   input  logic                  mgmt_waitrequest,
   input  logic                  pll_locked,
   output logic                  pll_reset,
   output logic                  busy,
   output logic                  done,
   output logic                  lock_err,
   output logic [PW-1:0]         pos,
   output logic                  auto,
   output logic                  auto_end
);

   localparam int W  = 7 + NUM_C;
   localparam int WW = $clog2(W);
   localparam int CW = $clog2(GAP);
   localparam logic [PW-1:0] LAST = PW'(ENTRIES - 1);

   state_e          state, state_nx;
   logic [WW-1:0]   widx, widx_nx;
   logic [CW-1:0]   cnt, cnt_nx;
   logic            issued, issued_nx;
   logic [31:0]     tmo, tmo_nx;
   logic [PW-1:0]   pos_nx;
   logic            auto_nx, lock_err_nx, done_nx, auto_end_nx;
   logic            start;
   logic            locked_s;
   logic [5:0]      wr_addr;
   logic [31:0]     wr_data;

   pll_sync2 u_lock_sync (
      .CLK_50M (CLK_50M),
      .RESET   (RESET),
      .d       (pll_locked),
      .q       (locked_s)
   );

   assign busy           = (state != S_IDLE);
   assign cmd_ready      = ~busy;
   assign pll_reset      = (state == S_PRST);
   assign tbl_idx        = pos;
   assign mgmt_address   = mgmt_write ? wr_addr : 6'd0;
   assign mgmt_writedata = mgmt_write ? wr_data : 32'd0;

   // Write list: START, M, K, N bypass, C counters, CP, BW, APPLY.
   always_comb begin
      wr_addr = ADDR_APPLY;
      wr_data = '0;
      case (int'(widx))
         0: wr_addr = ADDR_START;
         1: begin wr_addr = ADDR_M; wr_data = tbl_m; end
         2: begin wr_addr = ADDR_K; wr_data = tbl_k; end
         3: begin wr_addr = ADDR_N; wr_data = N_BYPASS; end
         default: begin
            if (int'(widx) == W - 3) begin
               wr_addr = ADDR_CP;
               wr_data = CP_VAL;
            end else if (int'(widx) == W - 2) begin
               wr_addr = ADDR_BW;
               wr_data = BW_VAL;
            end else if (int'(widx) < W - 3) begin
               wr_addr = ADDR_C;
               for (int i = 0; i < NUM_C; i++)
                  if (int'(widx) == 4 + i) wr_data = tbl_c[32*i +: 32];
            end
         end
      endcase
   end

   always_comb begin
      state_nx    = state;
      widx_nx     = widx;
      cnt_nx      = cnt;
      issued_nx   = issued;
      tmo_nx      = tmo;
      pos_nx      = pos;
      auto_nx     = auto;
      lock_err_nx = lock_err;
      done_nx     = 1'b0;
      auto_end_nx = 1'b0;
      start       = 1'b0;
      mgmt_write  = 1'b0;
      case (state)
         S_IDLE: begin
            // A command in the same cycle as auto_pass takes priority.
            if (cmd_valid) begin
               case (cmd_op)
                  OP_UP: if (pos < LAST) begin
                     pos_nx = pos + 1'b1; auto_nx = 1'b0; start = 1'b1;
                  end
                  OP_DOWN: if (pos != '0) begin
                     pos_nx = pos - 1'b1; auto_nx = 1'b0; start = 1'b1;
                  end
                  OP_REAPPLY: begin
                     auto_nx = 1'b0; start = 1'b1;
                  end
                  OP_AUTO_START: begin
                     pos_nx = '0; auto_nx = 1'b1; start = 1'b1;
                  end
                  OP_SET: if (int'(cmd_idx) < ENTRIES) begin
                     pos_nx = cmd_idx; auto_nx = 1'b0; start = 1'b1;
                  end
                  default: ;
               endcase
            end else if (auto && auto_pass) begin
               if (pos < LAST) begin
                  pos_nx = pos + 1'b1;
                  start  = 1'b1;
               end else begin
                  auto_nx     = 1'b0;
                  auto_end_nx = 1'b1;
               end
            end
            if (start) begin
               state_nx    = S_WRITE;
               widx_nx     = '0;
               issued_nx   = 1'b0;
               lock_err_nx = 1'b0;
            end
         end
         S_WRITE: begin
            // Slot timing starts only once the write has actually gone out.
            if (!issued) begin
               if (!mgmt_waitrequest) begin
                  mgmt_write = 1'b1;
                  issued_nx  = 1'b1;
                  cnt_nx     = CW'(1);
               end
            end else if (cnt == CW'(GAP - 1)) begin
               issued_nx = 1'b0;
               if (widx == WW'(W - 1)) begin
                  state_nx = S_PRST;
                  cnt_nx   = '0;
               end else begin
                  widx_nx = widx + 1'b1;
               end
            end else begin
               cnt_nx = cnt + 1'b1;
            end
         end
         S_PRST: begin
            if (cnt == CW'(GAP - 1)) begin
               state_nx = S_SETTLE;
               cnt_nx   = '0;
            end else begin
               cnt_nx = cnt + 1'b1;
            end
         end
         S_SETTLE: begin
            if (cnt == CW'(GAP - 1)) begin
               state_nx = S_LOCKWAIT;
               tmo_nx   = '0;
            end else begin
               cnt_nx = cnt + 1'b1;
            end
         end
         S_LOCKWAIT: begin
            if (locked_s) begin
               state_nx = S_IDLE;
               done_nx  = 1'b1;
            end else if (tmo == 32'(LOCK_TIMEOUT - 1)) begin
               state_nx    = S_IDLE;
               done_nx     = 1'b1;
               lock_err_nx = 1'b1;
            end else if (tmo != '1) begin
               tmo_nx = tmo + 1'b1;
            end
         end
         default: state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge CLK_50M) begin
      if (RESET) begin
         state    <= S_IDLE;
         widx     <= '0;
         cnt      <= '0;
         issued   <= 1'b0;
         tmo      <= '0;
         pos      <= '0;
         auto     <= 1'b0;
         lock_err <= 1'b0;
         done     <= 1'b0;
         auto_end <= 1'b0;
      end else begin
         state    <= state_nx;
         widx     <= widx_nx;
         cnt      <= cnt_nx;
         issued   <= issued_nx;
         tmo      <= tmo_nx;
         pos      <= pos_nx;
         auto     <= auto_nx;
         lock_err <= lock_err_nx;
         done     <= done_nx;
         auto_end <= auto_end_nx;
      end
   end

endmodule

// File: tb/tb_pll_recfg_seq.sv
// Directed bench for pll_recfg_seq with a small table (3 entries) and a short lock timeout.
module tb_pll_recfg_seq;
   import pll_recfg_pkg::*;

   localparam int ENTRIES      = 3;
   localparam int NUM_C        = 1;
   localparam int GAP          = 8;
   localparam int LOCK_TIMEOUT = 100;
   localparam int PW           = 2;

   logic          CLK_50M = 1'b0;
   logic          RESET = 1'b1;
   logic          cmd_valid = 1'b0;
   logic [2:0]    cmd_op = 3'd0;
   logic [PW-1:0] cmd_idx = '0;
   logic          auto_pass = 1'b0;
   logic          mgmt_waitrequest = 1'b0;
   logic          pll_locked = 1'b0;
   logic          cmd_ready, mgmt_write, pll_reset, busy, done, lock_err, auto, auto_end;
   logic [PW-1:0] tbl_idx, pos;
   logic [31:0]   tbl_m, tbl_k, mgmt_writedata;
   logic [32*NUM_C-1:0] tbl_c;
   logic [5:0]    mgmt_address;

   int n_chk = 0, n_fail = 0;
   int cyc = 0, acc_cyc = 0;
   int wr_n = 0, done_n = 0, done_cyc = 0, auto_end_n = 0;
   int prst_rise = -1000, prst_fall = -1000;
   logic prst_prev = 1'b0;
   logic lock_en = 1'b1;
   int          wr_cyc [256];
   logic [5:0]  wr_adr [256];
   logic [31:0] wr_dat [256];

   assign tbl_m = 32'hA000_0000 | {30'd0, tbl_idx};
   assign tbl_k = 32'hB000_0000 | {30'd0, tbl_idx};
   assign tbl_c = 32'hC000_0000 | {30'd0, tbl_idx};

   pll_recfg_seq #(
      .ENTRIES(ENTRIES), .NUM_C(NUM_C), .GAP(GAP), .LOCK_TIMEOUT(LOCK_TIMEOUT)
   ) dut (
      .CLK_50M(CLK_50M), .RESET(RESET),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_idx(cmd_idx),
      .auto_pass(auto_pass), .tbl_idx(tbl_idx), .tbl_m(tbl_m), .tbl_k(tbl_k), .tbl_c(tbl_c),
      .mgmt_address(mgmt_address), .mgmt_writedata(mgmt_writedata), .mgmt_write(mgmt_write),
      .mgmt_waitrequest(mgmt_waitrequest), .pll_locked(pll_locked), .pll_reset(pll_reset),
      .busy(busy), .done(done), .lock_err(lock_err), .pos(pos), .auto(auto), .auto_end(auto_end)
   );

   always #10 CLK_50M = ~CLK_50M;

   always @(posedge CLK_50M) cyc = cyc + 1;

   // Event log plus a PLL model: lock drops during reset and returns 10 cycles after it ends.
   always @(negedge CLK_50M) begin
      if (cmd_valid && cmd_ready) acc_cyc = cyc;
      if (mgmt_write && wr_n < 256) begin
         wr_cyc[wr_n] = cyc;
         wr_adr[wr_n] = mgmt_address;
         wr_dat[wr_n] = mgmt_writedata;
         wr_n = wr_n + 1;
      end
      if (done) begin done_n = done_n + 1; done_cyc = cyc; end
      if (auto_end) auto_end_n = auto_end_n + 1;
      if (pll_reset && !prst_prev) prst_rise = cyc;
      if (!pll_reset && prst_prev) prst_fall = cyc;
      prst_prev = pll_reset;
      if (pll_reset) pll_locked = 1'b0;
      else if (lock_en && cyc == prst_fall + 10) pll_locked = 1'b1;
   end

   function automatic logic [5:0] exp_addr(input int i);
      case (i)
         0: return 6'd0;  1: return 6'd4;  2: return 6'd7;  3: return 6'd3;
         4: return 6'd5;  5: return 6'd9;  6: return 6'd8;  default: return 6'd2;
      endcase
   endfunction

   function automatic logic [31:0] exp_data(input int i, input int p);
      case (i)
         1: return 32'hA000_0000 + 32'(p);
         2: return 32'hB000_0000 + 32'(p);
         3: return 32'h0001_0000;
         4: return 32'hC000_0000 + 32'(p);
         5: return 32'd1;
         6: return 32'd7;
         default: return 32'd0;
      endcase
   endfunction

   task automatic issue_cmd(input logic [2:0] op, input logic [PW-1:0] idx);
      @(posedge CLK_50M); #1;
      cmd_valid = 1'b1; cmd_op = op; cmd_idx = idx;
      @(posedge CLK_50M); #1;
      cmd_valid = 1'b0;
   endtask

   task automatic pulse_pass();
      @(posedge CLK_50M); #1; auto_pass = 1'b1;
      @(posedge CLK_50M); #1; auto_pass = 1'b0;
   endtask

   task automatic test_reset();
      repeat (3) @(posedge CLK_50M);
      #1 RESET = 1'b0;
      @(negedge CLK_50M);
      n_chk++;
      if ({busy, cmd_ready, pll_reset, mgmt_write, done, lock_err, auto, auto_end} !== 8'b0100_0000) begin
         n_fail++;
         $display("FAIL reset_flags: got %b exp 01000000",
                  {busy, cmd_ready, pll_reset, mgmt_write, done, lock_err, auto, auto_end});
      end
      n_chk++;
      if ({pos, tbl_idx, mgmt_address, mgmt_writedata} !== '0) begin
         n_fail++;
         $display("FAIL reset_buses: pos %0d tbl_idx %0d addr %0d data %h, exp all 0",
                  pos, tbl_idx, mgmt_address, mgmt_writedata);
      end
   endtask

   task automatic test_auto_start();
      int t, wb, db;
      wb = wr_n; db = done_n;
      issue_cmd(OP_AUTO_START, 2'd0);
      t = acc_cyc;
      repeat (100) @(posedge CLK_50M);
      @(negedge CLK_50M);
      n_chk++;
      if (wr_n - wb !== 8) begin n_fail++; $display("FAIL auto_start wr_count: got %0d exp 8", wr_n - wb); end
      for (int i = 0; i < 8; i++) begin
         n_chk++;
         if (wr_cyc[wb+i] !== t + 1 + GAP*i) begin
            n_fail++; $display("FAIL auto_start wr%0d_cycle: got %0d exp %0d", i, wr_cyc[wb+i] - t, 1 + GAP*i);
         end
         n_chk++;
         if (wr_adr[wb+i] !== exp_addr(i)) begin
            n_fail++; $display("FAIL auto_start wr%0d_addr: got %0d exp %0d", i, wr_adr[wb+i], exp_addr(i));
         end
         n_chk++;
         if (wr_dat[wb+i] !== exp_data(i, 0)) begin
            n_fail++; $display("FAIL auto_start wr%0d_data: got %h exp %h", i, wr_dat[wb+i], exp_data(i, 0));
         end
      end
      n_chk++;
      if (prst_rise - t !== 65 || prst_fall - t !== 73) begin
         n_fail++; $display("FAIL auto_start pll_reset: high %0d..%0d exp 65..72", prst_rise - t, prst_fall - t - 1);
      end
      n_chk++;
      if (done_n - db !== 1 || done_cyc - t !== 86) begin
         n_fail++; $display("FAIL auto_start done: count %0d at %0d exp 1 at 86", done_n - db, done_cyc - t);
      end
      n_chk++;
      if (pos !== 2'd0 || auto !== 1'b1 || lock_err !== 1'b0 || busy !== 1'b0) begin
         n_fail++; $display("FAIL auto_start status: pos %0d auto %b err %b busy %b exp 0 1 0 0", pos, auto, lock_err, busy);
      end
   endtask

   task automatic test_auto_sweep();
      int wb, db, ab;
      for (int p = 1; p <= 2; p++) begin
         wb = wr_n; db = done_n;
         pulse_pass();
         repeat (100) @(posedge CLK_50M);
         @(negedge CLK_50M);
         n_chk++;
         if (pos !== PW'(p) || auto !== 1'b1 || done_n - db !== 1 || wr_n - wb !== 8) begin
            n_fail++; $display("FAIL sweep_step%0d: pos %0d auto %b done %0d writes %0d exp %0d 1 1 8",
                               p, pos, auto, done_n - db, wr_n - wb, p);
         end
         n_chk++;
         if (wr_dat[wb+1] !== exp_data(1, p)) begin
            n_fail++; $display("FAIL sweep_step%0d m_word: got %h exp %h", p, wr_dat[wb+1], exp_data(1, p));
         end
      end
      wb = wr_n; db = done_n; ab = auto_end_n;
      pulse_pass();
      repeat (30) @(posedge CLK_50M);
      @(negedge CLK_50M);
      n_chk++;
      if (auto_end_n - ab !== 1 || auto !== 1'b0) begin
         n_fail++; $display("FAIL sweep_end: auto_end %0d auto %b exp 1 0", auto_end_n - ab, auto);
      end
      n_chk++;
      if (wr_n - wb !== 0 || done_n - db !== 0 || busy !== 1'b0 || pos !== 2'd2) begin
         n_fail++; $display("FAIL sweep_end_nostart: writes %0d done %0d busy %b pos %0d exp 0 0 0 2",
                            wr_n - wb, done_n - db, busy, pos);
      end
   endtask

   task automatic test_boundaries();
      int wb, db;
      wb = wr_n; db = done_n;
      issue_cmd(OP_UP, 2'd0);
      repeat (20) @(posedge CLK_50M);
      @(negedge CLK_50M);
      n_chk++;
      if (wr_n - wb !== 0 || done_n - db !== 0 || pos !== 2'd2 || busy !== 1'b0) begin
         n_fail++; $display("FAIL up_at_top: writes %0d done %0d pos %0d busy %b exp 0 0 2 0", wr_n - wb, done_n - db, pos, busy);
      end
      issue_cmd(OP_SET, 2'd3);
      repeat (20) @(posedge CLK_50M);
      @(negedge CLK_50M);
      n_chk++;
      if (wr_n - wb !== 0 || done_n - db !== 0 || pos !== 2'd2) begin
         n_fail++; $display("FAIL set_out_of_range: writes %0d done %0d pos %0d exp 0 0 2", wr_n - wb, done_n - db, pos);
      end
      issue_cmd(OP_SET, 2'd0);
      repeat (100) @(posedge CLK_50M);
      @(negedge CLK_50M);
      n_chk++;
      if (pos !== 2'd0 || done_n - db !== 1 || wr_n - wb !== 8) begin
         n_fail++; $display("FAIL set_zero: pos %0d done %0d writes %0d exp 0 1 8", pos, done_n - db, wr_n - wb);
      end
      wb = wr_n; db = done_n;
      issue_cmd(OP_DOWN, 2'd0);
      repeat (20) @(posedge CLK_50M);
      @(negedge CLK_50M);
      n_chk++;
      if (wr_n - wb !== 0 || done_n - db !== 0 || pos !== 2'd0 || busy !== 1'b0) begin
         n_fail++; $display("FAIL down_at_zero: writes %0d done %0d pos %0d busy %b exp 0 0 0 0", wr_n - wb, done_n - db, pos, busy);
      end
   endtask

   task automatic test_waitrequest();
      int t, wb, db, ecyc;
      wb = wr_n; db = done_n;
      issue_cmd(OP_REAPPLY, 2'd0);
      t = acc_cyc;
      repeat (16) @(posedge CLK_50M);
      #1 mgmt_waitrequest = 1'b1;
      repeat (5) @(posedge CLK_50M);
      #1 mgmt_waitrequest = 1'b0;
      repeat (100) @(posedge CLK_50M);
      @(negedge CLK_50M);
      n_chk++;
      if (wr_n - wb !== 8) begin n_fail++; $display("FAIL waitreq wr_count: got %0d exp 8", wr_n - wb); end
      for (int i = 0; i < 8; i++) begin
         ecyc = (i < 2) ? 1 + GAP*i : 6 + GAP*i;
         n_chk++;
         if (wr_cyc[wb+i] - t !== ecyc || wr_adr[wb+i] !== exp_addr(i)) begin
            n_fail++; $display("FAIL waitreq wr%0d: cycle %0d addr %0d exp %0d addr %0d",
                               i, wr_cyc[wb+i] - t, wr_adr[wb+i], ecyc, exp_addr(i));
         end
      end
      n_chk++;
      if (prst_rise - t !== 70 || done_n - db !== 1 || done_cyc - t !== 91) begin
         n_fail++; $display("FAIL waitreq tail: prst %0d done %0d at %0d exp 70 1 91", prst_rise - t, done_n - db, done_cyc - t);
      end
   endtask

   task automatic test_timeout();
      int t, db;
      lock_en = 1'b0;
      db = done_n;
      issue_cmd(OP_REAPPLY, 2'd0);
      t = acc_cyc;
      repeat (200) @(posedge CLK_50M);
      @(negedge CLK_50M);
      n_chk++;
      if (done_n - db !== 1 || done_cyc - t !== 81 + LOCK_TIMEOUT) begin
         n_fail++; $display("FAIL timeout_done: count %0d at %0d exp 1 at %0d", done_n - db, done_cyc - t, 81 + LOCK_TIMEOUT);
      end
      n_chk++;
      if (lock_err !== 1'b1 || busy !== 1'b0) begin
         n_fail++; $display("FAIL timeout_err: lock_err %b busy %b exp 1 0", lock_err, busy);
      end
      lock_en = 1'b1;
      db = done_n;
      issue_cmd(OP_REAPPLY, 2'd0);
      @(negedge CLK_50M);
      n_chk++;
      if (lock_err !== 1'b0 || busy !== 1'b1) begin
         n_fail++; $display("FAIL reapply_clears_err: lock_err %b busy %b exp 0 1", lock_err, busy);
      end
      repeat (100) @(posedge CLK_50M);
      @(negedge CLK_50M);
      n_chk++;
      if (done_n - db !== 1 || lock_err !== 1'b0) begin
         n_fail++; $display("FAIL reapply_locks: done %0d lock_err %b exp 1 0", done_n - db, lock_err);
      end
   endtask

   task automatic test_busy_and_reset();
      int wb, db;
      wb = wr_n; db = done_n;
      issue_cmd(OP_REAPPLY, 2'd0);
      repeat (4) @(posedge CLK_50M);
      #1 begin cmd_valid = 1'b1; cmd_op = OP_UP; end
      @(negedge CLK_50M);
      n_chk++;
      if (cmd_ready !== 1'b0) begin n_fail++; $display("FAIL busy_ready: got %b exp 0", cmd_ready); end
      repeat (3) @(posedge CLK_50M);
      #1 cmd_valid = 1'b0;
      repeat (100) @(posedge CLK_50M);
      @(negedge CLK_50M);
      n_chk++;
      if (pos !== 2'd0 || done_n - db !== 1 || wr_n - wb !== 8) begin
         n_fail++; $display("FAIL busy_cmd_dropped: pos %0d done %0d writes %0d exp 0 1 8", pos, done_n - db, wr_n - wb);
      end
      issue_cmd(OP_SET, 2'd2);
      repeat (9) @(posedge CLK_50M);
      #1 begin cmd_valid = 1'b1; cmd_op = OP_UP; end
      repeat (3) @(posedge CLK_50M);
      #1 cmd_valid = 1'b0;
      repeat (7) @(posedge CLK_50M);
      #1 RESET = 1'b1;
      @(negedge CLK_50M);
      n_chk++;
      if (busy !== 1'b1 || pos !== 2'd2) begin
         n_fail++; $display("FAIL pre_reset: busy %b pos %0d exp 1 2", busy, pos);
      end
      @(posedge CLK_50M);
      #1 RESET = 1'b0;
      @(negedge CLK_50M);
      n_chk++;
      if ({busy, cmd_ready, pll_reset, mgmt_write, done, lock_err, auto, auto_end} !== 8'b0100_0000 ||
          pos !== 2'd0 || mgmt_address !== 6'd0 || mgmt_writedata !== 32'd0) begin
         n_fail++; $display("FAIL reset_abort: flags %b pos %0d addr %0d exp 01000000 0 0",
                            {busy, cmd_ready, pll_reset, mgmt_write, done, lock_err, auto, auto_end}, pos, mgmt_address);
      end
      wb = wr_n; db = done_n;
      repeat (120) @(posedge CLK_50M);
      @(negedge CLK_50M);
      n_chk++;
      if (wr_n - wb !== 0 || done_n - db !== 0 || pos !== 2'd0 || busy !== 1'b0) begin
         n_fail++; $display("FAIL post_reset_quiet: writes %0d done %0d pos %0d busy %b exp 0 0 0 0",
                            wr_n - wb, done_n - db, pos, busy);
      end
   endtask

   initial begin
      test_reset();
      test_auto_start();
      test_auto_sweep();
      test_boundaries();
      test_waitrequest();
      test_timeout();
      test_busy_and_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/pll_recfg_seq.md
# pll_recfg_seq

Parametrised PLL reconfiguration sequencer for the memory-test core. It sits between the keyboard/OSD command logic and the Altera `pll_cfg` management port. On command it steps through an external frequency table of M/K/C words and programs the PLL. It pulses the PLL reset, then waits for lock with a timeout. It also supports an auto-sweep mode that advances one table entry per pass indication from the tester.

## Interface
Parameters:
- ENTRIES, 38: number of table entries; pos width PW = $clog2(ENTRIES).
- NUM_C, 1: output counters programmed per entry (1..4).
- GAP, 8: cycles per write slot (≥2).
- LOCK_TIMEOUT, 5000000: max cycles waiting for lock (100 ms).

Ports:
- CLK_50M  in  1  clock.
- RESET  in  1  reset, synchronous, active-high.
- cmd_valid  in  1  command strobe.
- cmd_ready  out  1  = ~busy.
- cmd_op  in  3  0 UP, 1 DOWN, 2 REAPPLY, 3 AUTO_START, 4 SET; 5–7 are ignored.
- cmd_idx  in  PW  target index for SET.
- auto_pass  in  1  one-cycle pulse: current setting passed.
- tbl_idx  out  PW  table row being read (= pos).
- tbl_m, tbl_k  in  32 each  M and K words for tbl_idx (combinational table).
- tbl_c  in  32*NUM_C  complete C-counter words; counter i is in bits [32i+31:32i].
- mgmt_address  out  6.
- mgmt_writedata  out  32.
- mgmt_write  out  1.
- mgmt_waitrequest  in  1.
- pll_locked  in  1  asynchronous; double-flopped internally.
- pll_reset  out  1.
- busy  out  1.
- done  out  1  one-cycle pulse at the end of a sequence.
- lock_err  out  1  sticky; cleared by the next accepted command.
- pos  out  PW  current table index.
- auto  out  1  auto-sweep active.
- auto_end  out  1  one-cycle pulse when auto-sweep reaches the last entry.

## Operation
- States: IDLE → WRITE → PRST → SETTLE → LOCKWAIT → IDLE.
- Command handling in IDLE:
  - UP: if pos < ENTRIES-1, pos+1 and start; otherwise no-op (no start, no done).
  - DOWN: if pos > 0, pos-1 and start; otherwise no-op.
  - REAPPLY: start at the same pos.
  - SET: if cmd_idx < ENTRIES, pos = cmd_idx and start; otherwise no-op.
  - AUTO_START: pos = 0, auto = 1, start.
  - UP, DOWN, REAPPLY and SET clear auto.
- Every started command clears lock_err.
- Write list, W = 7 + NUM_C writes, as (addr, data):
  - (0, 0)
  - (4, M)
  - (7, K)
  - (3, 'h10000)
  - (5, C[i]) for i = 0..NUM_C-1
  - (9, 1)
  - (8, 7)
  - (2, 0)
- Write issue: one write per slot. mgmt_write is a one-cycle pulse, issued in the first cycle of the slot in which mgmt_waitrequest is low. While waitrequest is high the slot stalls and its GAP count does not start.
- PRST: pll_reset = 1 for GAP cycles.
- SETTLE: GAP cycles during which lock is ignored.
- LOCKWAIT: exits on synchronised locked = 1, or after LOCK_TIMEOUT cycles, which sets lock_err. Either exit pulses done.
- Auto step: in IDLE with auto = 1 and auto_pass = 1:
  - if pos < ENTRIES-1: pos+1 and start;
  - if pos = ENTRIES-1: pulse auto_end and clear auto.
- A cmd_valid and auto_pass in the same IDLE cycle: the command wins and auto_pass is dropped. auto_pass while busy is ignored.
- Table words are sampled in the cycle each write issues; pos is stable throughout a sequence.

## Timing
- Reset values: all outputs 0 (pos = 0, auto = 0, busy = 0, pll_reset = 0, mgmt_* = 0, lock_err = 0); cmd_ready = 1.
- Command accepted at cycle t (cmd_valid & cmd_ready).
- busy = 1 and first mgmt_write at t+1.
- With no waitrequest, write k issues at t+1+k·GAP.
- pll_reset is high over [t+1+W·GAP, t+W·GAP+GAP].
- LOCKWAIT begins at t+1+(W+2)·GAP.
- done pulses the cycle after lock is seen; busy falls the same cycle.
- Lock latency includes 2 synchroniser cycles.
- Timeout counter: 32 bits, saturating.
- RESET mid-sequence aborts immediately: the next cycle shows pll_reset = 0, mgmt_write = 0, IDLE.

## Structure
- Package pll_recfg_pkg:
  - op enum;
  - state enum;
  - mgmt address localparams (START 0, N 3, M 4, C 5, K 7, BW 8, CP 9, APPLY 2);
  - constant data N_BYPASS 'h10000, CP_VAL 1, BW_VAL 7.
- One sub-module, pll_sync2: double-flop synchroniser for pll_locked.
- Write-list index counter: $clog2(W) bits; slot counter: $clog2(GAP) bits.

## Test plan
- Reset, then AUTO_START with NUM_C=1, GAP=8, no waitrequest, locked returning 10 cycles after pll_reset falls → 8 writes at t+1, t+9 … t+57 with the exact (addr, data) list; pll_reset high t+65..t+72; done pulses; pos = 0; auto = 1.
- UP at pos = ENTRIES-1 and DOWN at pos = 0 → no mgmt_write, no done, pos unchanged.
- Waitrequest held high for 5 cycles during the K slot → K write delayed 5 cycles, all later writes shift by 5, none dropped or duplicated.
- locked held low, LOCK_TIMEOUT=100 → done and lock_err at LOCKWAIT+100; the next REAPPLY clears lock_err.
- Auto sweep with ENTRIES=3: auto_pass after each done → pos goes 0→1→2; the third auto_pass pulses auto_end, clears auto, and starts no sequence.
- RESET asserted mid-WRITE, plus cmd_valid while busy → immediate IDLE with all outputs 0; the busy-time command is never executed.
